// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide stall controller.
//   - MD opcode encodings as seen on E_md_op / md_op
//   - FSM state enum
//   - default busy latencies for mult/multu and div/divu
package md_ctrl_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Divides are distinguished from multiplies by the upper opcode bit.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter that times one MD operation.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   load_i       load load_val_i this edge (takes priority over counting)
//   load_val_i   busy latency of the operation being started
//   en_i         decrement this edge (saturates at zero, never wraps)
//   last_o       counter holds 1: current cycle is the final busy cycle
module md_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/md_stall_ctrl.sv
// Sequencer for the shared multiply/divide unit of the 5-stage pipeline.
// Tracks MD occupancy, strobes the HI/LO write on the final busy cycle and
// merges the MD hazard stall with the external data-hazard stall to drive
// the F/D/E pipeline-register controls.
// Ports:
//   clk, reset      pipeline clock / asynchronous active-high reset
//   E_md_start      MD instruction valid in E (sampled with E_md_op, E_div_zero)
//   E_md_op         00 mult, 01 multu, 10 div, 11 divu
//   E_div_zero      divisor is zero
//   D_md_use        instruction in D touches the MD unit or HI/LO
//   D_stall_data    external data-hazard stall
//   md_busy         MD unit occupied
//   md_op           op latched for the running (or last) operation
//   hilo_we         one-cycle HI/LO write strobe
//   stall           global stall
//   F_PC_en, D_REG_en, E_REG_flush   pipeline controls derived from stall
//   md_err          sticky: start seen while busy
module md_stall_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E_md_start,
  input  logic [1:0] E_md_op,
  input  logic       E_div_zero,
  input  logic       D_md_use,
  input  logic       D_stall_data,
  output logic       md_busy,
  output logic [1:0] md_op,
  output logic       hilo_we,
  output logic       stall,
  output logic       F_PC_en,
  output logic       D_REG_en,
  output logic       E_REG_flush,
  output logic       md_err
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       dz_q, dz_d;
  logic       err_q, err_d;
  logic       cnt_load;
  logic       cnt_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic       md_stall;

  assign cnt_load_val = md_is_div(E_md_op) ? DIV_LOAD : MULT_LOAD;

  md_latency_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (md_busy),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dz_d     = dz_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (E_md_start) begin
          state_d  = BUSY;
          op_d     = E_md_op;
          dz_d     = E_div_zero;
          cnt_load = 1'b1;
        end
      end
      BUSY: begin
        // A second start cannot be queued: it is dropped and flagged.
        if (E_md_start) err_d = 1'b1;
        if (cnt_last)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q == BUSY);
  assign md_op   = op_q;
  assign md_err  = err_q;

  // Divide-by-zero leaves HI/LO untouched but keeps the normal busy window.
  assign hilo_we = md_busy & cnt_last & ~(md_is_div(op_q) & dz_q);

  // Start in E counts immediately so D cannot slip past the op being issued.
  assign md_stall    = D_md_use & (E_md_start | md_busy);
  assign stall       = D_stall_data | md_stall;
  assign F_PC_en     = ~stall;
  assign D_REG_en    = ~stall;
  assign E_REG_flush = stall;

endmodule
